// File: rtl/exec_ctrl_pkg.sv
// Shared definitions for the multi-cycle execution controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the controller state encoding, the ALU operation codes and the
// generic enable/disable levels used by exec_ctrl and its environment.
package exec_ctrl_pkg;

    // Controller phases. Each instruction walks FETCH -> DECODE -> EXEC ->
    // (MEM) -> WB and back to FETCH.
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    // ALU operation codes. ALU_ADD is the idle code driven outside EXEC.
    localparam logic [5:0] ALU_ADD  = 6'd0;
    localparam logic [5:0] ALU_SUB  = 6'd1;
    localparam logic [5:0] ALU_AND  = 6'd2;
    localparam logic [5:0] ALU_OR   = 6'd3;
    localparam logic [5:0] ALU_XOR  = 6'd4;
    localparam logic [5:0] ALU_SLL  = 6'd5;
    localparam logic [5:0] ALU_SRL  = 6'd6;
    localparam logic [5:0] ALU_SRA  = 6'd7;
    localparam logic [5:0] ALU_SLT  = 6'd8;
    localparam logic [5:0] ALU_SLTU = 6'd9;
    localparam logic [5:0] ALU_LUI  = 6'd10;
    localparam logic [5:0] ALU_BEQ  = 6'd16;
    localparam logic [5:0] ALU_BNE  = 6'd17;
    localparam logic [5:0] ALU_BLT  = 6'd18;
    localparam logic [5:0] ALU_BGE  = 6'd19;
    localparam logic [5:0] ALU_BLTU = 6'd20;
    localparam logic [5:0] ALU_BGEU = 6'd21;
    localparam logic [5:0] ALU_JAL  = 6'd22;
    localparam logic [5:0] ALU_JALR = 6'd23;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    // Branch/jump targets are forced onto a word boundary.
    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/exec_ctrl_if.sv
// Bus bundle between exec_ctrl and its surroundings (imem, decoder, ALU,
// dmem, register file). Latency: n/a (wires only).
// Backpressure: imem/dmem use req/ack; the controller holds req until ack.
//
// master : the execution controller
// slave  : the environment (memories, decoder, ALU, register file)
interface exec_ctrl_if;

    // instruction memory
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    // decoder / register file
    logic [31:0] ir;
    logic [5:0]  dec_alucode;
    logic        dec_is_load;
    logic        dec_is_store;
    logic        dec_reg_we;
    logic [31:0] dec_target;

    // ALU
    logic [5:0]  alu_code;
    logic [31:0] alu_result;
    logic        br_taken;

    // data memory
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    // write-back and architectural state
    logic        rf_we;
    logic [31:0] rf_wdata;
    logic [31:0] pc;
    logic [31:0] instret;

    modport master (
        output imem_req, imem_addr, ir, alu_code,
        output dmem_req, dmem_we, dmem_addr,
        output rf_we, rf_wdata, pc, instret,
        input  imem_ack, imem_rdata,
        input  dec_alucode, dec_is_load, dec_is_store, dec_reg_we, dec_target,
        input  alu_result, br_taken,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, ir, alu_code,
        input  dmem_req, dmem_we, dmem_addr,
        input  rf_we, rf_wdata, pc, instret,
        output imem_ack, imem_rdata,
        output dec_alucode, dec_is_load, dec_is_store, dec_reg_we, dec_target,
        output alu_result, br_taken,
        output dmem_ack, dmem_rdata
    );

endinterface

// File: rtl/exec_ctrl.sv
// Multi-cycle execution controller: fetch/decode/exec/mem/wb sequencing.
// Latency: 4 cycles ALU/branch, 5 cycles load/store, +1 per memory wait.
// Backpressure: holds imem_req/dmem_req and stalls in place until *_ack.
//
// Ports:
//   clk      core clock, all state updates on the rising edge
//   rst_n    synchronous active-low reset
//   bus      exec_ctrl_if.master: imem req/ack, decoder inputs, ALU code and
//            result, dmem req/ack, register-file write, pc and instret
//
// Every output is decoded from registered state (plus the stable decoder
// inputs); no *_ack reaches a *_req combinationally.
module exec_ctrl
    import exec_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst_n,
    exec_ctrl_if.master bus
);

    state_e      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] ir_q,      ir_d;
    logic [31:0] instret_q, instret_d;
    logic [31:0] res_q,     res_d;
    logic [31:0] tgt_q,     tgt_d;
    logic [31:0] ld_q,      ld_d;
    logic        taken_q,   taken_d;

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            pc_q      <= RESET_PC;
            ir_q      <= '0;
            instret_q <= '0;
            res_q     <= '0;
            tgt_q     <= '0;
            ld_q      <= '0;
            taken_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            instret_q <= instret_d;
            res_q     <= res_d;
            tgt_q     <= tgt_d;
            ld_q      <= ld_d;
            taken_q   <= taken_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ir_d      = ir_q;
        instret_d = instret_q;
        res_d     = res_q;
        tgt_d     = tgt_q;
        ld_d      = ld_q;
        taken_d   = taken_q;

        case (state_q)
            ST_FETCH: begin
                if (bus.imem_ack) begin
                    ir_d    = bus.imem_rdata;
                    state_d = ST_DECODE;
                end
            end

            // One settle cycle for the decoder and register-file read.
            ST_DECODE: begin
                state_d = ST_EXEC;
            end

            // The ALU result, branch decision and target are captured here so
            // the ALU is free to show the idle code for the rest of the
            // instruction.
            ST_EXEC: begin
                res_d   = bus.alu_result;
                taken_d = bus.br_taken;
                tgt_d   = align_word(bus.dec_target);
                state_d = (bus.dec_is_load || bus.dec_is_store) ? ST_MEM : ST_WB;
            end

            ST_MEM: begin
                if (bus.dmem_ack) begin
                    if (bus.dec_is_load) begin
                        ld_d = bus.dmem_rdata;
                    end
                    state_d = ST_WB;
                end
            end

            // Architectural state advances only on leaving WB.
            ST_WB: begin
                pc_d      = taken_q ? tgt_q : (pc_q + 32'd4);
                instret_d = instret_q + 32'd1;
                state_d   = ST_FETCH;
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        bus.imem_req = DISABLE;
        bus.dmem_req = DISABLE;
        bus.dmem_we  = DISABLE;
        bus.rf_we    = DISABLE;
        bus.alu_code = ALU_ADD;

        case (state_q)
            ST_FETCH: begin
                bus.imem_req = ENABLE;
            end
            ST_EXEC: begin
                bus.alu_code = bus.dec_alucode;
            end
            ST_MEM: begin
                bus.dmem_req = ENABLE;
                bus.dmem_we  = bus.dec_is_store;
            end
            ST_WB: begin
                // Stores never write rd even if the decoder flags reg_we.
                bus.rf_we = bus.dec_reg_we & ~bus.dec_is_store;
            end
            default: begin
                bus.imem_req = DISABLE;
            end
        endcase
    end

    // Write data is only qualified by rf_we, so the mux runs in every state.
    assign bus.rf_wdata  = bus.dec_is_load ? ld_q : res_q;
    assign bus.imem_addr = pc_q;
    assign bus.dmem_addr = res_q;
    assign bus.ir        = ir_q;
    assign bus.pc        = pc_q;
    assign bus.instret   = instret_q;

endmodule

// File: tb/tb_exec_ctrl.sv
// Self-checking bench for exec_ctrl: directed scenarios followed by a run of
// randomized instructions. The bench plays imem, decoder, ALU and dmem, and
// predicts every cycle's outputs from the instruction-level rules.
module tb_exec_ctrl;
    import exec_ctrl_pkg::*;

    localparam logic [31:0] RESET_PC = 32'h0000_8000;

    localparam int T_ALU = 0;
    localparam int T_BR  = 1;
    localparam int T_LD  = 2;
    localparam int T_ST  = 3;

    logic clk = 1'b0;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    // architectural model
    logic [31:0] m_pc;
    logic [31:0] m_instret;

    exec_ctrl_if bus ();

    exec_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One whole instruction, starting in its first FETCH cycle and ending in
    // the first FETCH cycle of the next one. iw/dw are the number of wait
    // cycles before imem/dmem acknowledge.
    task automatic run_instr(input int typ, input int iw, input int dw,
                             input logic [31:0] instr, input logic [5:0] code,
                             input logic [31:0] res, input logic taken,
                             input logic [31:0] target, input logic [31:0] ld,
                             input logic reg_we);
        logic is_ld;
        logic is_st;
        is_ld = (typ == T_LD);
        is_st = (typ == T_ST);

        for (int k = 0; k <= iw; k++) begin
            chk1("fetch_imem_req", bus.imem_req, 1'b1);
            chk ("fetch_imem_addr", bus.imem_addr, m_pc);
            chk1("fetch_rf_we", bus.rf_we, 1'b0);
            chk1("fetch_dmem_req", bus.dmem_req, 1'b0);
            bus.imem_ack   = (k == iw);
            bus.imem_rdata = (k == iw) ? instr : $urandom;
            step();
        end

        // Spurious acks outside FETCH must not disturb ir.
        bus.imem_ack     = 1'($urandom_range(0, 1));
        bus.imem_rdata   = ~instr;
        bus.dec_alucode  = code;
        bus.dec_is_load  = is_ld;
        bus.dec_is_store = is_st;
        bus.dec_reg_we   = reg_we;
        bus.dec_target   = target;
        bus.alu_result   = res;
        bus.br_taken     = taken;

        // DECODE
        chk ("decode_ir", bus.ir, instr);
        chk1("decode_imem_req", bus.imem_req, 1'b0);
        chk ("decode_alu_code", 32'(bus.alu_code), 32'(ALU_ADD));
        step();

        // EXEC
        chk ("exec_alu_code", 32'(bus.alu_code), 32'(code));
        chk ("exec_ir", bus.ir, instr);
        chk ("exec_pc", bus.pc, m_pc);
        chk1("exec_rf_we", bus.rf_we, 1'b0);
        step();

        // Values seen after EXEC must be ignored.
        bus.alu_result = $urandom;
        bus.br_taken   = 1'($urandom_range(0, 1));

        if (is_ld || is_st) begin
            for (int k = 0; k <= dw; k++) begin
                chk1("mem_dmem_req", bus.dmem_req, 1'b1);
                chk1("mem_dmem_we", bus.dmem_we, is_st);
                chk ("mem_dmem_addr", bus.dmem_addr, res);
                chk1("mem_rf_we", bus.rf_we, 1'b0);
                chk1("mem_imem_req", bus.imem_req, 1'b0);
                bus.dmem_ack   = (k == dw);
                bus.dmem_rdata = (k == dw) ? ld : $urandom;
                step();
            end
        end
        bus.dmem_ack   = 1'($urandom_range(0, 1));
        bus.dmem_rdata = $urandom;

        // WB
        chk1("wb_rf_we", bus.rf_we, reg_we && !is_st);
        chk ("wb_rf_wdata", bus.rf_wdata, is_ld ? ld : res);
        chk1("wb_dmem_req", bus.dmem_req, 1'b0);
        chk1("wb_imem_req", bus.imem_req, 1'b0);
        chk ("wb_pc", bus.pc, m_pc);
        chk ("wb_instret", bus.instret, m_instret);
        step();

        m_pc      = taken ? {target[31:2], 2'b00} : m_pc + 32'd4;
        m_instret = m_instret + 32'd1;
        bus.dmem_ack = 1'b0;

        chk ("next_pc", bus.pc, m_pc);
        chk ("next_instret", bus.instret, m_instret);
        chk ("next_ir", bus.ir, instr);
        chk1("next_rf_we", bus.rf_we, 1'b0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk1({tag, "_imem_req"}, bus.imem_req, 1'b1);
        chk ({tag, "_imem_addr"}, bus.imem_addr, RESET_PC);
        chk ({tag, "_pc"}, bus.pc, RESET_PC);
        chk ({tag, "_instret"}, bus.instret, 32'd0);
        chk ({tag, "_ir"}, bus.ir, 32'd0);
        chk1({tag, "_dmem_req"}, bus.dmem_req, 1'b0);
        chk1({tag, "_rf_we"}, bus.rf_we, 1'b0);
        chk ({tag, "_alu_code"}, 32'(bus.alu_code), 32'(ALU_ADD));
    endtask

    initial begin
        int          typ;
        int          iw;
        int          dw;
        logic        taken;
        logic        reg_we;
        logic [5:0]  code;
        logic [31:0] tgt;

        rst_n            = 1'b0;
        bus.imem_ack     = 1'b0;
        bus.imem_rdata   = '0;
        bus.dec_alucode  = ALU_ADD;
        bus.dec_is_load  = 1'b0;
        bus.dec_is_store = 1'b0;
        bus.dec_reg_we   = 1'b0;
        bus.dec_target   = '0;
        bus.alu_result   = '0;
        bus.br_taken     = 1'b0;
        bus.dmem_ack     = 1'b0;
        bus.dmem_rdata   = '0;

        step();
        step();
        chk_reset_state("reset");
        rst_n     = 1'b1;
        m_pc      = RESET_PC;
        m_instret = 32'd0;

        // ADD producing 7 with zero-wait memories.
        run_instr(T_ALU, 0, 0, 32'h0020_81B3, ALU_ADD, 32'd7, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("add_pc", bus.pc, 32'h0000_8004);
        chk("add_instret", bus.instret, 32'd1);

        // BEQ taken to 0x8100, then not taken.
        run_instr(T_BR, 0, 0, 32'h0020_8063, ALU_BEQ, 32'd0, 1'b1, 32'h0000_8100, 32'h0, 1'b0);
        chk("beq_taken_addr", bus.imem_addr, 32'h0000_8100);
        run_instr(T_BR, 0, 0, 32'h0020_8063, ALU_BEQ, 32'd0, 1'b0, 32'h0000_9000, 32'h0, 1'b0);
        chk("beq_not_taken_addr", bus.imem_addr, 32'h0000_8104);

        // Load with three dmem wait cycles.
        run_instr(T_LD, 0, 3, 32'h0000_A183, ALU_ADD, 32'h0000_2000, 1'b0, 32'h0,
                  32'hDEAD_BEEF, 1'b1);

        // Store that the decoder flags as writing rd.
        run_instr(T_ST, 1, 1, 32'h0030_A023, ALU_ADD, 32'h0000_2004, 1'b0, 32'h0,
                  32'h0, 1'b1);
        chk("store_instret", bus.instret, 32'd5);

        // Jump to the top word (target bits [1:0] dropped), then wrap.
        run_instr(T_BR, 0, 0, 32'h0000_006F, ALU_JAL, 32'h0, 1'b1, 32'hFFFF_FFFF,
                  32'h0, 1'b1);
        chk("jump_top_pc", bus.pc, 32'hFFFF_FFFC);
        run_instr(T_ALU, 2, 0, 32'h0020_C1B3, ALU_XOR, 32'h55, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("wrap_pc", bus.pc, 32'h0000_0000);

        // Reset in the middle of a load's memory wait; the ack arrives late.
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h0000_A283;
        step();
        bus.imem_ack     = 1'b0;
        bus.dec_alucode  = ALU_ADD;
        bus.dec_is_load  = 1'b1;
        bus.dec_is_store = 1'b0;
        bus.dec_reg_we   = 1'b1;
        bus.alu_result   = 32'h0000_3000;
        step();
        step();
        chk1("abort_dmem_req", bus.dmem_req, 1'b1);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n          = 1'b1;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'h1234_5678;
        chk_reset_state("abort");
        for (int k = 0; k < 3; k++) begin
            step();
            chk1("late_ack_rf_we", bus.rf_we, 1'b0);
            chk1("late_ack_dmem_req", bus.dmem_req, 1'b0);
            chk1("late_ack_imem_req", bus.imem_req, 1'b1);
            chk ("late_ack_pc", bus.pc, RESET_PC);
            chk ("late_ack_instret", bus.instret, 32'd0);
        end
        bus.dmem_ack = 1'b0;
        m_pc         = RESET_PC;
        m_instret    = 32'd0;

        // Randomized instruction stream.
        for (int n = 0; n < 80; n++) begin
            typ    = int'($urandom_range(0, 3));
            iw     = int'($urandom_range(0, 2));
            dw     = int'($urandom_range(0, 3));
            taken  = 1'b0;
            reg_we = 1'($urandom_range(0, 1));
            tgt    = $urandom;
            case (typ)
                T_ALU:   code = 6'($urandom_range(1, 10));
                T_BR: begin
                    code  = 6'($urandom_range(16, 23));
                    taken = 1'($urandom_range(0, 1));
                end
                T_LD: begin
                    code   = ALU_ADD;
                    reg_we = 1'b1;
                end
                default: code = ALU_ADD;
            endcase
            run_instr(typ, iw, dw, $urandom, code, $urandom, taken, tgt, $urandom, reg_we);
        end
        chk("final_instret", bus.instret, 32'd80);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
